// File: rtl/lcd_16207_pkg.sv
// Shared definitions for the 16207 character-LCD bus sequencer.
// Holds the access state enumeration, the default strobe timing in clock
// cycles, and a helper that turns a phase length into a timer load value.
package lcd_16207_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_DONE
  } lcd_state_e;

  localparam int unsigned DEF_SETUP_CYC = 4;   // RS/RW/data valid to E rise
  localparam int unsigned DEF_PULSE_CYC = 25;  // E high time
  localparam int unsigned DEF_HOLD_CYC  = 2;   // RS/RW/data hold after E fall

  // The timer reaches zero on the last cycle of a phase, so a phase of
  // N cycles loads N-1.
  function automatic logic [7:0] cyc_to_load(input int unsigned cyc);
    return 8'(cyc - 32'd1);
  endfunction

endpackage

// File: rtl/lcd_16207_timer.sv
// Loadable 8-bit down-counter used to time each phase of an LCD access.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset (count -> 0)
//   load          - load load_val this cycle (has priority over counting)
//   load_val      - value to load
//   zero          - count is zero
// The counter decrements while non-zero and then rests at zero.
module lcd_16207_timer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/lcd_16207_sequencer.sv
// Avalon-MM slave that turns single register accesses into timed HD44780 /
// 16207 bus cycles: setup, enable pulse, hold, then one DONE cycle in which
// waitrequest drops.
// Ports:
//   clk, reset_n            - clock, asynchronous active-low reset
//   address[1:0]            - bit0 = RW (1 = read), bit1 = RS
//   read, write, writedata  - Avalon request; held by master while stalled
//   readdata                - byte captured from the LCD on the E fall edge
//   waitrequest             - stall, low only in the DONE cycle
//   LCD_E, LCD_RS, LCD_RW   - registered LCD control lines
//   LCD_data                - bidirectional LCD bus, driven only during writes
module lcd_16207_sequencer
  import lcd_16207_pkg::*;
#(
  parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
  parameter int unsigned PULSE_CYC = DEF_PULSE_CYC,
  parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] address,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       waitrequest,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  inout  logic [7:0] LCD_data
);

  lcd_state_e state_q, state_d;
  logic       lcd_e_q, lcd_e_d;
  logic       lcd_rs_q, lcd_rs_d;
  logic       lcd_rw_q, lcd_rw_d;
  logic       drive_q, drive_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] readdata_q, readdata_d;

  logic       tmr_load;
  logic [7:0] tmr_val;
  logic       tmr_zero;

  lcd_16207_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d    = state_q;
    lcd_e_d    = lcd_e_q;
    lcd_rs_d   = lcd_rs_q;
    lcd_rw_d   = lcd_rw_q;
    drive_d    = drive_q;
    wdata_d    = wdata_q;
    readdata_d = readdata_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;

    case (state_q)
      ST_IDLE: begin
        if (read || write) begin
          state_d  = ST_SETUP;
          lcd_rs_d = address[1];
          // A simultaneous read and write is treated as a write.
          lcd_rw_d = address[0] & ~write;
          wdata_d  = writedata;
          drive_d  = write;
          tmr_load = 1'b1;
          tmr_val  = cyc_to_load(SETUP_CYC);
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          state_d  = ST_PULSE;
          lcd_e_d  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = cyc_to_load(PULSE_CYC);
        end
      end
      ST_PULSE: begin
        if (tmr_zero) begin
          state_d  = ST_HOLD;
          lcd_e_d  = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = cyc_to_load(HOLD_CYC);
          if (lcd_rw_q) begin
            readdata_d = LCD_data;
          end
        end
      end
      ST_HOLD: begin
        if (tmr_zero) begin
          state_d = ST_DONE;
          drive_d = 1'b0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        lcd_e_d = 1'b0;
        drive_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      lcd_e_q    <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_rw_q   <= 1'b0;
      drive_q    <= 1'b0;
      wdata_q    <= '0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      lcd_e_q    <= lcd_e_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_rw_q   <= lcd_rw_d;
      drive_q    <= drive_d;
      wdata_q    <= wdata_d;
      readdata_q <= readdata_d;
    end
  end

  assign waitrequest = (read || write) && (state_q != ST_DONE);
  assign readdata    = readdata_q;
  assign LCD_E       = lcd_e_q;
  assign LCD_RS      = lcd_rs_q;
  assign LCD_RW      = lcd_rw_q;
  assign LCD_data    = drive_q ? wdata_q : 'z;

endmodule

// File: tb/tb_lcd_16207_sequencer.sv
// Scoreboard bench for lcd_16207_sequencer: default-timing instance plus a
// 1/1/1-timing instance. Stimulus pushes expected completions; monitors
// check strobe shape, bus contents and completion latency.
module tb_lcd_16207_sequencer;

  localparam int S   = 4;
  localparam int P   = 25;
  localparam int H   = 2;
  localparam int LAT = 1 + S + P + H;
  localparam int DV  = S + P + H;

  typedef struct {
    int         done_cyc;
    logic       is_rd;
    logic       rs;
    logic       rw;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] address;
  logic       read, write;
  logic [7:0] writedata, readdata;
  logic       waitrequest, lcd_e, lcd_rs, lcd_rw;
  tri   [7:0] lcd_bus;
  logic       tb_drv;
  logic [7:0] tb_val;
  assign lcd_bus = tb_drv ? tb_val : 'z;

  logic [1:0] f_address;
  logic       f_read, f_write;
  logic [7:0] f_writedata, f_readdata;
  logic       f_waitrequest, f_lcd_e, f_lcd_rs, f_lcd_rw;
  tri   [7:0] f_bus;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  int   fq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_16207_sequencer u_dut (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read),
    .write(write), .writedata(writedata), .readdata(readdata),
    .waitrequest(waitrequest), .LCD_E(lcd_e), .LCD_RS(lcd_rs),
    .LCD_RW(lcd_rw), .LCD_data(lcd_bus)
  );

  lcd_16207_sequencer #(.SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) u_fast (
    .clk(clk), .reset_n(reset_n), .address(f_address), .read(f_read),
    .write(f_write), .writedata(f_writedata), .readdata(f_readdata),
    .waitrequest(f_waitrequest), .LCD_E(f_lcd_e), .LCD_RS(f_lcd_rs),
    .LCD_RW(f_lcd_rw), .LCD_data(f_bus)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Called at a negedge; ofs=1 when the DUT is in DONE and the request will
  // first be seen in the following IDLE cycle.
  task automatic issue(input logic [1:0] a, input logic rd, input logic wr,
                       input logic [7:0] wd, input int ofs);
    exp_t e;
    address   = a;
    read      = rd;
    write     = wr;
    writedata = wd;
    e.done_cyc = cyc + ofs + LAT;
    e.is_rd    = rd & ~wr;
    e.rs       = a[1];
    e.rw       = a[0] & ~wr;
    e.data     = wd;
    tb_val     = 8'hA5;
    tb_drv     = e.is_rd;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (waitrequest && n < 200);
    chk("wait_bound", waitrequest, 0);
  endtask

  task automatic idle();
    read   = 1'b0;
    write  = 1'b0;
    tb_drv = 1'b0;
  endtask

  initial begin : mon_main
    int   e_cnt, lo_cnt, dv_cnt;
    bit   e_prev, seen_fall;
    exp_t e;
    e_cnt = 0; lo_cnt = 0; dv_cnt = 0; e_prev = 0; seen_fall = 0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n) begin
        e_cnt = 0; lo_cnt = 0; dv_cnt = 0; e_prev = 0; seen_fall = 0;
      end else begin
        if (sb.size() > 0 && !sb[0].is_rd && lcd_bus === sb[0].data) dv_cnt++;
        if (lcd_e) begin
          if (!e_prev) begin
            if (seen_fall) chk("strobe_gap", int'(lo_cnt >= S + H + 2), 1);
            if (sb.size() > 0) begin
              chk("rs_at_strobe", lcd_rs, sb[0].rs);
              chk("rw_at_strobe", lcd_rw, sb[0].rw);
            end
          end
          if (sb.size() > 0 && sb[0].is_rd) chk("bus_during_read", lcd_bus, 8'hA5);
          e_cnt++;
        end else begin
          if (e_prev) begin
            chk("strobe_width", e_cnt, P);
            e_cnt = 0;
            lo_cnt = 0;
            seen_fall = 1;
          end
          lo_cnt++;
        end
        e_prev = lcd_e;
        if ((read || write) && !waitrequest) begin
          if (sb.size() == 0) begin
            chk("done_without_request", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            chk("latency", cyc, e.done_cyc);
            if (e.is_rd) chk("readdata", readdata, 8'hA5);
            else         chk("data_valid_cycles", dv_cnt, DV);
          end
          dv_cnt = 0;
        end
      end
    end
  end

  initial begin : mon_fast
    int fe_cnt, d;
    bit fe_prev;
    fe_cnt = 0; fe_prev = 0;
    forever begin
      @(posedge clk); #1;
      if (f_lcd_e) begin
        fe_cnt++;
        chk("fast_bus", f_bus, 8'h6B);
      end else if (fe_prev) begin
        chk("fast_strobe_width", fe_cnt, 1);
        fe_cnt = 0;
      end
      fe_prev = f_lcd_e;
      if (f_write && !f_waitrequest) begin
        if (fq.size() == 0) begin
          chk("fast_done_without_request", fq.size(), 1);
        end else begin
          d = fq.pop_front();
          chk("fast_latency", cyc, d);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin : stim
    int n;
    reset_n = 1'b0;
    address = '0; read = 1'b0; write = 1'b0; writedata = '0;
    f_address = 2'b10; f_read = 1'b0; f_write = 1'b0; f_writedata = 8'h6B;
    tb_drv = 1'b1; tb_val = 8'h3C;
    repeat (3) @(negedge clk);
    chk("reset_lcd_e", lcd_e, 0);
    chk("reset_lcd_rs", lcd_rs, 0);
    chk("reset_lcd_rw", lcd_rw, 0);
    chk("reset_readdata", readdata, 0);
    chk("reset_bus_released", lcd_bus, 8'h3C);
    chk("reset_fast_lcd_e", f_lcd_e, 0);
    reset_n = 1'b1;
    tb_drv = 1'b0;
    repeat (2) @(negedge clk);

    // Plain data write
    issue(2'b10, 1'b0, 1'b1, 8'h41, 0); wait_done(); idle();
    repeat (2) @(negedge clk);

    // Read while the bench drives the bus
    issue(2'b01, 1'b1, 1'b0, 8'h00, 0); wait_done(); idle();
    repeat (2) @(negedge clk);

    // read and write together behave as a write
    issue(2'b01, 1'b1, 1'b1, 8'h0C, 0); wait_done(); idle();
    repeat (2) @(negedge clk);

    // Back-to-back writes
    issue(2'b10, 1'b0, 1'b1, 8'h38, 0); wait_done();
    issue(2'b00, 1'b0, 1'b1, 8'h0F, 1); wait_done(); idle();
    repeat (2) @(negedge clk);

    // Master illegally changes address/data mid-access
    issue(2'b10, 1'b0, 1'b1, 8'h55, 0);
    repeat (6) @(negedge clk);
    address = 2'b01; writedata = 8'hAA;
    wait_done(); idle();
    repeat (2) @(negedge clk);

    // Request withdrawn mid-access: sequence completes, next access is normal
    address = 2'b10; writedata = 8'h77; write = 1'b1;
    repeat (3) @(negedge clk);
    write = 1'b0;
    repeat (45) @(negedge clk);
    issue(2'b00, 1'b0, 1'b1, 8'h01, 0); wait_done(); idle();
    repeat (2) @(negedge clk);

    // Reset in the 10th PULSE cycle
    issue(2'b10, 1'b0, 1'b1, 8'h99, 0);
    repeat (S + 10) @(negedge clk);
    chk("lcd_e_before_reset", lcd_e, 1);
    reset_n = 1'b0;
    tb_val = 8'hC3; tb_drv = 1'b1;
    #1;
    chk("lcd_e_dropped_by_reset", lcd_e, 0);
    chk("bus_released_by_reset", lcd_bus, 8'hC3);
    sb.delete();
    write = 1'b0;
    repeat (2) @(negedge clk);
    tb_drv = 1'b0;
    reset_n = 1'b1;
    issue(2'b10, 1'b0, 1'b1, 8'h21, 0); wait_done(); idle();
    repeat (2) @(negedge clk);

    // Minimum timing instance, two accesses
    for (int k = 0; k < 2; k++) begin
      f_write = 1'b1;
      fq.push_back(cyc + 4);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (f_waitrequest && n < 50);
      chk("fast_wait_bound", f_waitrequest, 0);
      f_write = 1'b0;
      repeat (3) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size() + fq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
